// File: rtl/time_counter_core.sv
// Cascaded hh:mm:ss:cc time counter with built-in tick divider, up/down count,
// per-field edit, clamped parallel load, countdown completion and lap capture.
module time_counter_core #(
   parameter int CLK_HZ           = 100_000_000,
   parameter int TICK_HZ          = 100,
   parameter int HOUR_MOD         = 24,
   parameter int RESET_HOUR       = 0,
   parameter bit SATURATE_AT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_run,
   input  logic        i_mode_down,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [23:0] i_load_time,
   input  logic        i_edit_en,
   input  logic [1:0]  i_edit_field,
   input  logic        i_edit_up,
   input  logic        i_edit_down,
   input  logic        i_lap,
   output logic [23:0] o_time,
   output logic [23:0] o_lap_time,
   output logic        o_lap_valid,
   output logic        o_running,
   output logic        o_done,
   output logic        o_tick
);

   localparam int              DIV       = CLK_HZ / TICK_HZ;
   localparam int              DIV_W     = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [4:0]      HOUR_MAX  = 5'(HOUR_MOD - 1);
   localparam logic [4:0]      HOUR_INIT = 5'(RESET_HOUR);

   logic [4:0]       t_hour;
   logic [5:0]       t_min;
   logic [5:0]       t_sec;
   logic [6:0]       t_cc;
   logic [DIV_W-1:0] div_cnt;

   logic run_eff, tick_now, edit_step;
   logic cc_max, sec_max, min_max, hour_max;
   logic cc_zero, sec_zero, min_zero, hour_zero;
   logic all_zero, one_left;
   logic [6:0] cc_inc, cc_dec, ld_cc;
   logic [5:0] sec_inc, sec_dec, min_inc, min_dec, ld_sec, ld_min;
   logic [4:0] hour_inc, hour_dec, ld_hour;

   assign o_time    = {t_hour, t_min, t_sec, t_cc};
   assign run_eff   = i_run & ~i_edit_en & ~o_done;
   assign o_running = run_eff;
   assign tick_now  = run_eff & (div_cnt == DIV_LAST);
   assign edit_step = i_edit_en & (i_edit_up ^ i_edit_down);

   assign cc_max    = (t_cc == 7'd99);
   assign sec_max   = (t_sec == 6'd59);
   assign min_max   = (t_min == 6'd59);
   assign hour_max  = (t_hour == HOUR_MAX);
   assign cc_zero   = (t_cc == 7'd0);
   assign sec_zero  = (t_sec == 6'd0);
   assign min_zero  = (t_min == 6'd0);
   assign hour_zero = (t_hour == 5'd0);
   assign all_zero  = hour_zero & min_zero & sec_zero & cc_zero;
   assign one_left  = hour_zero & min_zero & sec_zero & (t_cc == 7'd1);

   // Single-field wrap steps, shared by the counting cascade and the editor.
   assign cc_inc   = cc_max    ? 7'd0     : t_cc + 7'd1;
   assign cc_dec   = cc_zero   ? 7'd99    : t_cc - 7'd1;
   assign sec_inc  = sec_max   ? 6'd0     : t_sec + 6'd1;
   assign sec_dec  = sec_zero  ? 6'd59    : t_sec - 6'd1;
   assign min_inc  = min_max   ? 6'd0     : t_min + 6'd1;
   assign min_dec  = min_zero  ? 6'd59    : t_min - 6'd1;
   assign hour_inc = hour_max  ? 5'd0     : t_hour + 5'd1;
   assign hour_dec = hour_zero ? HOUR_MAX : t_hour - 5'd1;

   assign ld_hour = (i_load_time[23:19] > HOUR_MAX) ? HOUR_MAX : i_load_time[23:19];
   assign ld_min  = (i_load_time[18:13] > 6'd59)    ? 6'd59    : i_load_time[18:13];
   assign ld_sec  = (i_load_time[12:7]  > 6'd59)    ? 6'd59    : i_load_time[12:7];
   assign ld_cc   = (i_load_time[6:0]   > 7'd99)    ? 7'd99    : i_load_time[6:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         t_hour      <= HOUR_INIT;
         t_min       <= '0;
         t_sec       <= '0;
         t_cc        <= '0;
         div_cnt     <= '0;
         o_done      <= 1'b0;
         o_tick      <= 1'b0;
         o_lap_time  <= '0;
         o_lap_valid <= 1'b0;
      end else begin
         o_tick <= 1'b0;
         if (i_clear) begin
            t_hour  <= HOUR_INIT;
            t_min   <= '0;
            t_sec   <= '0;
            t_cc    <= '0;
            div_cnt <= '0;
            o_done  <= 1'b0;
         end else if (i_load) begin
            t_hour  <= ld_hour;
            t_min   <= ld_min;
            t_sec   <= ld_sec;
            t_cc    <= ld_cc;
            div_cnt <= '0;
            o_done  <= 1'b0;
         end else if (edit_step) begin
            case (i_edit_field)
               2'd0:    t_cc   <= i_edit_up ? cc_inc   : cc_dec;
               2'd1:    t_sec  <= i_edit_up ? sec_inc  : sec_dec;
               2'd2:    t_min  <= i_edit_up ? min_inc  : min_dec;
               default: t_hour <= i_edit_up ? hour_inc : hour_dec;
            endcase
            o_done <= 1'b0;
         end else begin
            if (run_eff)
               div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (tick_now) begin
               o_tick <= 1'b1;
               if (!i_mode_down) begin
                  t_cc <= cc_inc;
                  if (cc_max) t_sec <= sec_inc;
                  if (cc_max && sec_max) t_min <= min_inc;
                  if (cc_max && sec_max && min_max) t_hour <= hour_inc;
               end else if (SATURATE_AT_ZERO && all_zero) begin
                  o_done <= 1'b1;
               end else begin
                  // Borrow chain; from all-zero this lands on the max time.
                  t_cc <= cc_dec;
                  if (cc_zero) t_sec <= sec_dec;
                  if (cc_zero && sec_zero) t_min <= min_dec;
                  if (cc_zero && sec_zero && min_zero) t_hour <= hour_dec;
                  if (SATURATE_AT_ZERO && one_left) o_done <= 1'b1;
               end
            end
            if (!i_mode_down) o_done <= 1'b0;
         end

         if (i_clear) begin
            o_lap_time  <= '0;
            o_lap_valid <= 1'b0;
         end else if (i_lap) begin
            o_lap_time  <= o_time;
            o_lap_valid <= 1'b1;
         end
      end
   end

endmodule
